// File: rtl/ble_packet_sync.sv
// ble_packet_sync: BLE link-layer access-address correlator and deframer.
//
// Consumes the recovered bit stream (value qualified by update and enable), hunts for
// ACCESS_ADDR with up to MAX_ERR bit errors, then assembles header, payload and CRC
// bytes LSB first and pushes them into an output FIFO.
//
// Optional feature macro: BLE_DEWHITEN_EN (adds the 7-bit de-whitening LFSR seeded
// from chan_idx; when undefined chan_idx is ignored and no LFSR exists).
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   enable         gates bit acceptance; low forces HUNT
//   update, value  bit strobe and recovered bit
//   chan_idx       BLE channel index (whitening seed)
//   m_data, m_last, m_valid, m_ready   output byte stream, m_last on final CRC byte
//   sync           pulse on access-address match
//   pkt_done       pulse on the final CRC byte write
//   len_err        sticky: header length above MAX_PDU
//   overflow       sticky: byte dropped on a full FIFO
//   pkt_count      completed packet counter
module ble_packet_sync #(
  parameter int unsigned         AA_WIDTH    = 32,
  parameter logic [AA_WIDTH-1:0] ACCESS_ADDR = 32'h8E89BED6,
  parameter int unsigned         MAX_ERR     = 1,
  parameter int unsigned         MAX_PDU     = 37,
  parameter int unsigned         FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        update,
  input  logic        value,
  input  logic [5:0]  chan_idx,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        sync,
  output logic        pkt_done,
  output logic        len_err,
  output logic        overflow,
  output logic [15:0] pkt_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned ErrW   = $clog2(AA_WIDTH + 1);
  localparam logic [7:0]  LenMax = 8'(MAX_PDU);

  typedef enum logic [1:0] {StHunt, StHeader, StPayload, StCrc} state_e;

  state_e              state_q, state_d;
  logic [AA_WIDTH-1:0] sr_q, sr_d, diff;
  logic [ErrW-1:0]     err_cnt;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]          len_q, len_d;
  logic                sync_q, sync_d;
  logic                wr_pend_q, wr_pend_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                wr_last_q, wr_last_d;
  logic                len_err_q, len_err_set;
  logic                overflow_q;
  logic [15:0]         pkt_count_q;

  logic [8:0]          mem [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       cnt_q;

  logic bit_acc, match, bit_in, abort, full, wr_ok, fifo_wr, fifo_rd;

  assign bit_acc = enable & update;

  // Correlator: shifts on every accepted bit regardless of state.
  assign sr_d = bit_acc ? {value, sr_q[AA_WIDTH-1:1]} : sr_q;

  always_comb begin
    diff    = sr_d ^ ACCESS_ADDR;
    err_cnt = '0;
    for (int i = 0; i < AA_WIDTH; i++) begin
      err_cnt = err_cnt + {{(ErrW-1){1'b0}}, diff[i]};
    end
    match = (err_cnt <= ErrW'(MAX_ERR));
  end

`ifdef BLE_DEWHITEN_EN
  logic [6:0] lfsr_q, lfsr_d;
  assign bit_in = value ^ lfsr_q[6];
  logic unused_bits;
  assign unused_bits = ^{sr_q[0], shift_q[0]};
`else
  assign bit_in = value;
  logic unused_bits;
  assign unused_bits = ^{sr_q[0], shift_q[0], chan_idx};
`endif

  // FIFO handshake: a full FIFO still takes a write if a read frees a slot this cycle.
  assign full    = (cnt_q == (PtrW+1)'(FIFO_DEPTH));
  assign m_valid = (cnt_q != '0);
  assign fifo_rd = m_valid & m_ready;
  assign wr_ok   = ~full | fifo_rd;
  assign fifo_wr = wr_pend_q & wr_ok;
  assign abort   = wr_pend_q & ~wr_ok;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    len_d       = len_q;
    sync_d      = 1'b0;
    wr_pend_d   = 1'b0;
    wr_data_d   = wr_data_q;
    wr_last_d   = 1'b0;
    len_err_set = 1'b0;
`ifdef BLE_DEWHITEN_EN
    lfsr_d      = lfsr_q;
`endif
    if (state_q == StHunt) begin
      if (bit_acc && match) begin
        state_d    = StHeader;
        sync_d     = 1'b1;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
`ifdef BLE_DEWHITEN_EN
        lfsr_d = {chan_idx[0], chan_idx[1], chan_idx[2], chan_idx[3], chan_idx[4],
                  chan_idx[5], 1'b1};
`endif
      end
    end else if (bit_acc) begin
      shift_d   = {bit_in, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef BLE_DEWHITEN_EN
      lfsr_d = {lfsr_q[5:4], lfsr_q[3] ^ lfsr_q[6], lfsr_q[2:0], lfsr_q[6]};
`endif
      if (bit_cnt_q == 3'd7) begin
        wr_pend_d  = 1'b1;
        wr_data_d  = shift_d;
        byte_cnt_d = byte_cnt_q + 8'd1;
        case (state_q)
          StHeader: begin
            if (byte_cnt_q == 8'd1) begin
              len_d      = shift_d;
              byte_cnt_d = '0;
              if (shift_d > LenMax) begin
                len_err_set = 1'b1;
                state_d     = StHunt;
              end else if (shift_d == 8'd0) begin
                state_d = StCrc;
              end else begin
                state_d = StPayload;
              end
            end
          end
          StPayload: begin
            if (byte_cnt_q == len_q - 8'd1) begin
              state_d    = StCrc;
              byte_cnt_d = '0;
            end
          end
          default: begin
            if (byte_cnt_q == 8'd2) begin
              wr_last_d = 1'b1;
              state_d   = StHunt;
            end
          end
        endcase
      end
    end
    // Disable or a refused FIFO write abandons the current packet.
    if (!enable || abort) state_d = StHunt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      sr_q        <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      len_q       <= '0;
      sync_q      <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_data_q   <= '0;
      wr_last_q   <= 1'b0;
      len_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
      pkt_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
`ifdef BLE_DEWHITEN_EN
      lfsr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      sync_q     <= sync_d;
      wr_pend_q  <= wr_pend_d;
      wr_data_q  <= wr_data_d;
      wr_last_q  <= wr_last_d;
`ifdef BLE_DEWHITEN_EN
      lfsr_q     <= lfsr_d;
`endif
      if (len_err_set) len_err_q <= 1'b1;
      if (abort) overflow_q <= 1'b1;
      if (pkt_done) pkt_count_q <= pkt_count_q + 16'd1;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   cnt_q <= cnt_q + (PtrW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q] <= {wr_last_q, wr_data_q};
  end

  assign m_data    = m_valid ? mem[rd_ptr_q][7:0] : 8'h00;
  assign m_last    = m_valid ? mem[rd_ptr_q][8] : 1'b0;
  assign sync      = sync_q;
  assign pkt_done  = fifo_wr & wr_last_q;
  assign len_err   = len_err_q;
  assign overflow  = overflow_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_ble_packet_sync.sv
// tb_ble_packet_sync: scoreboard bench for ble_packet_sync (default parameters).
// Expected bytes are queued as packets are built; a negedge monitor pops and compares
// every transferred byte. Define BLE_DEWHITEN_EN to whiten all stimulus and run the
// de-whitening scenario.
module tb_ble_packet_sync;

  localparam logic [31:0] AA = 32'h8E89BED6;

  logic        clk = 1'b0;
  logic        rst, enable, update, value, m_ready;
  logic [5:0]  chan_idx;
  logic [7:0]  m_data;
  logic        m_last, m_valid, sync, pkt_done, len_err, overflow;
  logic [15:0] pkt_count;

  int          checks = 0;
  int          failures = 0;
  int          sync_cnt = 0;
  int          done_cnt = 0;
  int          gap = 3;
  int          pkts_exp = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  mon_exp;
  logic [7:0]  tx[$];
  logic        wpos[7];
  logic        whiten_active = 1'b0;

  always #5 clk = ~clk;

  ble_packet_sync dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .update   (update),
    .value    (value),
    .chan_idx (chan_idx),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .sync     (sync),
    .pkt_done (pkt_done),
    .len_err  (len_err),
    .overflow (overflow),
    .pkt_count(pkt_count)
  );

  // Scoreboard monitor: a transfer happens at the next posedge when valid && ready.
  always @(negedge clk) begin
    if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: got data=%02h last=%0b, required no byte", m_data, m_last);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({m_last, m_data} !== mon_exp) begin
          failures++;
          $display("FAIL out_byte: got data=%02h last=%0b, required data=%02h last=%0b",
                   m_data, m_last, mon_exp[7:0], mon_exp[8]);
        end
      end
    end
    if (sync === 1'b1) sync_cnt++;
    if (pkt_done === 1'b1) done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one bit, applying the BLE whitening sequence when active.
  task automatic send_bit(input logic b);
    logic w;
    logic o;
    o = b;
    if (whiten_active) begin
      w = wpos[6];
      o = b ^ w;
      for (int k = 6; k > 0; k--) wpos[k] = wpos[k-1];
      wpos[4] = wpos[4] ^ w;
      wpos[0] = w;
    end
    update = 1'b1;
    value  = o;
    tick();
    update = 1'b0;
    value  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_sync(input logic [31:0] flip);
    logic [31:0] a;
    a = AA ^ flip;
    send_byte(8'hAA);
    for (int i = 0; i < 32; i++) send_bit(a[i]);
`ifdef BLE_DEWHITEN_EN
    wpos[0] = 1'b1;
    for (int k = 1; k < 7; k++) wpos[k] = chan_idx[6-k];
    whiten_active = 1'b1;
`endif
  endtask

  task automatic send_frame(input logic [31:0] flip);
    send_sync(flip);
    foreach (tx[i]) send_byte(tx[i]);
    whiten_active = 1'b0;
  endtask

  // Queues tx as expected output; the last byte carries m_last when full is set.
  task automatic push_tx(input int n, input bit full);
    for (int i = 0; i < n; i++) exp_q.push_back({full && (i == tx.size() - 1), tx[i]});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid === 1'b1) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL %s_drain: %0d bytes still expected, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({m_valid, m_last, sync, pkt_done, len_err, overflow} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b, required 000000",
               {m_valid, m_last, sync, pkt_done, len_err, overflow});
    end
    checks++;
    if (m_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got %02h, required 00", m_data);
    end
    checks++;
    if (pkt_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d, required 0", pkt_count);
    end
  endtask

  task automatic test_basic_packet();
    int s0, d0;
    s0 = sync_cnt;
    d0 = done_cnt;
    tx = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'hA1, 8'hB2, 8'hC3};
    push_tx(tx.size(), 1);
    send_frame(32'h0);
    wait_drain("basic");
    pkts_exp++;
    checks++;
    if (sync_cnt - s0 !== 1) begin
      failures++;
      $display("FAIL basic_sync: got %0d pulses, required 1", sync_cnt - s0);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL basic_done: got %0d pulses, required 1", done_cnt - d0);
    end
    checks++;
    if (pkt_count !== 16'(pkts_exp)) begin
      failures++;
      $display("FAIL basic_count: got %0d, required %0d", pkt_count, pkts_exp);
    end
    checks++;
    if ({len_err, overflow} !== 2'b00) begin
      failures++;
      $display("FAIL basic_flags: got %b, required 00", {len_err, overflow});
    end
  endtask

  task automatic test_aa_tolerance();
    int s0;
    s0 = sync_cnt;
    tx = '{8'h04, 8'h01, 8'h5A, 8'hA1, 8'hB2, 8'hC3};
    push_tx(tx.size(), 1);
    send_frame(32'h0000_0020);
    wait_drain("aa1");
    pkts_exp++;
    checks++;
    if (sync_cnt - s0 !== 1 || pkt_count !== 16'(pkts_exp)) begin
      failures++;
      $display("FAIL aa_1err: got sync=%0d count=%0d, required sync=1 count=%0d",
               sync_cnt - s0, pkt_count, pkts_exp);
    end
    s0 = sync_cnt;
    send_sync(32'h0010_0008);
    whiten_active = 1'b0;
    repeat (10) tick();
    checks++;
    if (sync_cnt - s0 !== 0) begin
      failures++;
      $display("FAIL aa_2err_sync: got %0d pulses, required 0", sync_cnt - s0);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL aa_2err_fifo: got m_valid=%b, required 0", m_valid);
    end
  endtask

  task automatic test_len_err();
    int d0;
    d0 = done_cnt;
    tx = '{8'h02, 8'h30};
    push_tx(2, 0);
    send_frame(32'h0);
    wait_drain("lenerr");
    checks++;
    if (len_err !== 1'b1) begin
      failures++;
      $display("FAIL len_err_flag: got %b, required 1", len_err);
    end
    tx = '{8'h01, 8'h00, 8'hC1, 8'hC2, 8'hC3};
    push_tx(tx.size(), 1);
    send_frame(32'h0);
    wait_drain("len0");
    pkts_exp++;
    checks++;
    if (done_cnt - d0 !== 1 || pkt_count !== 16'(pkts_exp)) begin
      failures++;
      $display("FAIL len_err_recover: got done=%0d count=%0d, required done=1 count=%0d",
               done_cnt - d0, pkt_count, pkts_exp);
    end
  endtask

  task automatic test_back_to_back();
    gap = 0;
    tx = '{8'h0E, 8'h02, 8'hDE, 8'hAD, 8'h5C, 8'h6D, 8'h7E};
    push_tx(tx.size(), 1);
    send_frame(32'h0);
    wait_drain("b2b");
    pkts_exp++;
    gap = 3;
    checks++;
    if (pkt_count !== 16'(pkts_exp)) begin
      failures++;
      $display("FAIL b2b_count: got %0d, required %0d", pkt_count, pkts_exp);
    end
  endtask

  task automatic test_overflow();
    int d0;
    d0 = done_cnt;
    m_ready = 1'b0;
    tx = '{8'h02, 8'h0F};
    for (int i = 0; i < 15; i++) tx.push_back(8'(i * 7 + 1));
    tx.push_back(8'hE1);
    tx.push_back(8'hE2);
    tx.push_back(8'hE3);
    push_tx(16, 0);
    send_frame(32'h0);
    repeat (10) tick();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag: got %b, required 1", overflow);
    end
    checks++;
    if (m_valid !== 1'b1 || done_cnt - d0 !== 0 || pkt_count !== 16'(pkts_exp)) begin
      failures++;
      $display("FAIL ovf_state: got valid=%b done=%0d count=%0d, required valid=1 done=0 count=%0d",
               m_valid, done_cnt - d0, pkt_count, pkts_exp);
    end
    m_ready = 1'b1;
    wait_drain("ovf");
  endtask

`ifdef BLE_DEWHITEN_EN
  task automatic test_dewhiten();
    chan_idx = 6'd37;
    tx = '{8'h02, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56};
    push_tx(tx.size(), 1);
    send_frame(32'h0);
    wait_drain("dewhiten");
    pkts_exp++;
    checks++;
    if (pkt_count !== 16'(pkts_exp)) begin
      failures++;
      $display("FAIL dewhiten_count: got %0d, required %0d", pkt_count, pkts_exp);
    end
  endtask
`endif

  task automatic test_reset_mid_packet();
    m_ready = 1'b0;
    tx = '{8'h02, 8'h05, 8'h11, 8'h22};
    send_sync(32'h0);
    foreach (tx[i]) send_byte(tx[i]);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    whiten_active = 1'b0;
    rst = 1'b1;
    tick();
    exp_q.delete();
    checks++;
    if ({m_valid, m_last, sync, pkt_done, len_err, overflow} !== 6'b0 || m_data !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_outputs: got flags=%b data=%02h, required 000000 00",
               {m_valid, m_last, sync, pkt_done, len_err, overflow}, m_data);
    end
    checks++;
    if (pkt_count !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_count: got %0d, required 0", pkt_count);
    end
    rst = 1'b0;
    m_ready = 1'b1;
    pkts_exp = 0;
    tick();
    tx = '{8'h02, 8'h02, 8'h77, 8'h88, 8'h91, 8'h92, 8'h93};
    push_tx(tx.size(), 1);
    send_frame(32'h0);
    wait_drain("rstmid");
    pkts_exp++;
    checks++;
    if (pkt_count !== 16'(pkts_exp)) begin
      failures++;
      $display("FAIL rstmid_next: got %0d, required %0d", pkt_count, pkts_exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b1;
    update   = 1'b0;
    value    = 1'b0;
    m_ready  = 1'b1;
    chan_idx = 6'd37;
    test_reset();
    test_basic_packet();
    test_aa_tolerance();
    test_len_err();
    test_back_to_back();
    test_overflow();
`ifdef BLE_DEWHITEN_EN
    test_dewhiten();
`endif
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
